// File: rtl/garduino_sys_v1_vjtag_pkg.sv
// Shared types and constants for the virtual-JTAG scan master.
package garduino_sys_v1_vjtag_pkg;

   localparam int unsigned DEF_DR_LEN = 38;

   // Instruction codes understood by the debug slave
   localparam logic [1:0] OCIMEM    = 2'd0;
   localparam logic [1:0] TRACEMEM  = 2'd1;
   localparam logic [1:0] BREAK     = 2'd2;
   localparam logic [1:0] TRACECTRL = 2'd3;

   typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, RESP} state_t;

endpackage

// File: rtl/garduino_sys_v1_vjtag_scan_master_if.sv
// Command/response handshake bundle between a requester and the scan master.
interface garduino_sys_v1_vjtag_scan_master_if
   import garduino_sys_v1_vjtag_pkg::*;
#(
   parameter int unsigned DR_LEN = DEF_DR_LEN,
   parameter int unsigned IR_W   = 2
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [IR_W-1:0]   cmd_ir;
   logic [DR_LEN-1:0] cmd_dr;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DR_LEN-1:0] rsp_dr;

   // Requester side
   modport master (
      output cmd_valid, cmd_ir, cmd_dr, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_dr
   );

   // Scan-master side
   modport slave (
      input  cmd_valid, cmd_ir, cmd_dr, rsp_ready,
      output cmd_ready, rsp_valid, rsp_dr
   );
endinterface

// File: rtl/garduino_sys_v1_vjtag_tck_gen.sv
// TCK divider: low then high for TCK_DIV clk cycles each while run is set.
// rise_en/fall_en flag the clk edge that will move tck 0->1 / 1->0.
module garduino_sys_v1_vjtag_tck_gen #(
   parameter int unsigned TCK_DIV = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic run,
   output logic tck,
   output logic rise_en,
   output logic fall_en
);
   localparam int unsigned CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(TCK_DIV - 1);

   logic [CW-1:0] div_q;
   logic          tck_q;
   logic          phase_end;

   assign phase_end = run && (div_q == DIV_LAST);
   assign rise_en   = phase_end && !tck_q;
   assign fall_en   = phase_end && tck_q;
   assign tck       = tck_q;

   // Phase counter; cleared and tck parked low whenever the scan is not running
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q <= '0;
         tck_q <= 1'b0;
      end else if (!run) begin
         div_q <= '0;
         tck_q <= 1'b0;
      end else if (div_q == DIV_LAST) begin
         div_q <= '0;
         tck_q <= ~tck_q;
      end else begin
         div_q <= div_q + CW'(1);
      end
   end
endmodule

// File: rtl/garduino_sys_v1_vjtag_scan_master.sv
// Virtual-JTAG scan master: one command in, full UIR/CDR/SDR/UDR/RTI sequence out,
// tdo captured into a response word.
module garduino_sys_v1_vjtag_scan_master
   import garduino_sys_v1_vjtag_pkg::*;
#(
   parameter int unsigned DR_LEN     = DEF_DR_LEN,
   parameter int unsigned IR_W       = 2,
   parameter int unsigned TCK_DIV    = 2,
   parameter int unsigned RTI_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   garduino_sys_v1_vjtag_scan_master_if.slave bus,
   output logic                 vji_tck,
   output logic                 vji_tdi,
   input  logic                 vji_tdo,
   output logic [IR_W-1:0]      vji_ir_in,
   output logic                 vji_uir,
   output logic                 vji_cdr,
   output logic                 vji_sdr,
   output logic                 vji_udr,
   output logic                 vji_rti
);
   localparam int unsigned BW = $clog2(DR_LEN + 1);
   localparam int unsigned RW = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES + 1) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(DR_LEN - 1);
   localparam logic [RW-1:0] RTI_LAST = RW'(RTI_CYCLES - 1);

   state_t            state_q;
   logic              cmd_ready_q, rsp_valid_q;
   logic [DR_LEN-1:0] rsp_dr_q, shift_q, shift_nxt, capture_q;
   logic [BW-1:0]     bit_cnt_q;
   logic [RW-1:0]     rti_cnt_q;
   logic [IR_W-1:0]   ir_q;
   logic              tdi_q, uir_q, cdr_q, sdr_q, udr_q, rti_q;
   logic              run, rise_en, fall_en;

   assign run       = (state_q != IDLE) && (state_q != RESP);
   assign shift_nxt = shift_q >> 1;

   garduino_sys_v1_vjtag_tck_gen #(
      .TCK_DIV (TCK_DIV)
   ) u_tck_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .run     (run),
      .tck     (vji_tck),
      .rise_en (rise_en),
      .fall_en (fall_en)
   );

   // Sequencer: accepts a command in IDLE, then advances one state per TCK falling edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_dr_q    <= '0;
         shift_q     <= '0;
         capture_q   <= '0;
         bit_cnt_q   <= '0;
         rti_cnt_q   <= '0;
         ir_q        <= '0;
         tdi_q       <= 1'b0;
         uir_q       <= 1'b0;
         cdr_q       <= 1'b0;
         sdr_q       <= 1'b0;
         udr_q       <= 1'b0;
         rti_q       <= 1'b0;
      end else begin
         // tdo is sampled as tck rises, so the slave's data has settled for a half-period
         if (rise_en && (state_q == SDR)) begin
            capture_q <= {vji_tdo, capture_q[DR_LEN-1:1]};
         end
         unique case (state_q)
            IDLE: begin
               if (bus.cmd_valid && cmd_ready_q) begin
                  ir_q        <= bus.cmd_ir;
                  shift_q     <= bus.cmd_dr;
                  cmd_ready_q <= 1'b0;
                  uir_q       <= 1'b1;
                  state_q     <= UIR;
               end
            end
            UIR: begin
               if (fall_en) begin
                  uir_q   <= 1'b0;
                  cdr_q   <= 1'b1;
                  state_q <= CDR;
               end
            end
            CDR: begin
               if (fall_en) begin
                  cdr_q     <= 1'b0;
                  sdr_q     <= 1'b1;
                  bit_cnt_q <= '0;
                  tdi_q     <= shift_q[0];
                  state_q   <= SDR;
               end
            end
            SDR: begin
               if (fall_en) begin
                  shift_q <= shift_nxt;
                  if (bit_cnt_q == BIT_LAST) begin
                     sdr_q   <= 1'b0;
                     udr_q   <= 1'b1;
                     tdi_q   <= 1'b0;
                     state_q <= UDR;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BW'(1);
                     tdi_q     <= shift_nxt[0];
                  end
               end
            end
            UDR: begin
               if (fall_en) begin
                  udr_q     <= 1'b0;
                  rti_q     <= 1'b1;
                  rti_cnt_q <= '0;
                  state_q   <= RTI;
               end
            end
            RTI: begin
               if (fall_en) begin
                  if (rti_cnt_q == RTI_LAST) begin
                     rti_q       <= 1'b0;
                     rsp_valid_q <= 1'b1;
                     rsp_dr_q    <= capture_q;
                     state_q     <= RESP;
                  end else begin
                     rti_cnt_q <= rti_cnt_q + RW'(1);
                  end
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_dr    = rsp_dr_q;
   assign vji_tdi       = tdi_q;
   assign vji_ir_in     = ir_q;
   assign vji_uir       = uir_q;
   assign vji_cdr       = cdr_q;
   assign vji_sdr       = sdr_q;
   assign vji_udr       = udr_q;
   assign vji_rti       = rti_q;
endmodule

// File: tb/tb_garduino_sys_v1_vjtag_scan_master.sv
// Directed bench for the scan master: default instance plus a fast-TCK instance.
module tb_garduino_sys_v1_vjtag_scan_master;
   import garduino_sys_v1_vjtag_pkg::*;

   localparam int unsigned L = 38;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   garduino_sys_v1_vjtag_scan_master_if #(.DR_LEN(L), .IR_W(2)) bus ();
   garduino_sys_v1_vjtag_scan_master_if #(.DR_LEN(L), .IR_W(2)) bus2 ();

   logic       tck, tdi, tdo, uir, cdr, sdr, udr, rti;
   logic [1:0] ir_in;
   logic       tck2, tdi2, tdo2, uir2, cdr2, sdr2, udr2, rti2;
   logic [1:0] ir_in2;

   garduino_sys_v1_vjtag_scan_master #(
      .DR_LEN(L), .IR_W(2), .TCK_DIV(2), .RTI_CYCLES(1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus),
      .vji_tck(tck), .vji_tdi(tdi), .vji_tdo(tdo), .vji_ir_in(ir_in),
      .vji_uir(uir), .vji_cdr(cdr), .vji_sdr(sdr), .vji_udr(udr), .vji_rti(rti)
   );

   garduino_sys_v1_vjtag_scan_master #(
      .DR_LEN(L), .IR_W(2), .TCK_DIV(1), .RTI_CYCLES(3)
   ) dut_fast (
      .clk(clk), .reset_n(reset_n), .bus(bus2),
      .vji_tck(tck2), .vji_tdi(tdi2), .vji_tdo(tdo2), .vji_ir_in(ir_in2),
      .vji_uir(uir2), .vji_cdr(cdr2), .vji_sdr(sdr2), .vji_udr(udr2), .vji_rti(rti2)
   );

   // Slave shift-register models
   logic [L-1:0] sr, sr_init, sr2, sr2_init;
   logic         sr_load = 1'b0, sr2_load = 1'b0;

   always @(posedge tck or posedge sr_load)
      if (sr_load) sr <= sr_init;
      else if (sdr) sr <= {tdi, sr[L-1:1]};
   assign tdo = sr[0];

   always @(posedge tck2 or posedge sr2_load)
      if (sr2_load) sr2 <= sr2_init;
      else if (sdr2) sr2 <= {tdi2, sr2[L-1:1]};
   assign tdo2 = sr2[0];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_sr(input logic [L-1:0] v);
      sr_init = v; sr_load = 1'b1; #1; sr_load = 1'b0;
   endtask

   task automatic load_sr2(input logic [L-1:0] v);
      sr2_init = v; sr2_load = 1'b1; #1; sr2_load = 1'b0;
   endtask

   // Ticks until the default instance raises rsp_valid, with a bound
   task automatic wait_rsp(output int n);
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 2000) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      repeat (3) tick();
      checks++;
      if ({bus.cmd_ready, bus.rsp_valid, tck, tdi, uir, cdr, sdr, udr, rti} !== 9'b1_0000_0000) begin
         failures++;
         $display("FAIL reset_held: got %b expected 100000000",
                  {bus.cmd_ready, bus.rsp_valid, tck, tdi, uir, cdr, sdr, udr, rti});
      end
      reset_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         checks++;
         if ({bus.cmd_ready, bus.rsp_valid, tck, tdi, uir, cdr, sdr, udr, rti, ir_in}
             !== 11'b1_0000_0000_00) begin
            failures++;
            $display("FAIL idle_cycle%0d: got %b expected 10000000000", i,
                     {bus.cmd_ready, bus.rsp_valid, tck, tdi, uir, cdr, sdr, udr, rti, ir_in});
         end
      end
      checks++;
      if ({bus2.cmd_ready, bus2.rsp_valid, tck2, uir2, sdr2} !== 5'b10000) begin
         failures++;
         $display("FAIL idle_fast: got %b expected 10000",
                  {bus2.cmd_ready, bus2.rsp_valid, tck2, uir2, sdr2});
      end
   endtask

   task automatic test_scan();
      logic [29:0] seq;
      logic [4:0]  cur, last;
      int n, sdr_clks, ir_bad;
      load_sr(38'h15_0F0F_F0F0);
      bus.cmd_ir = BREAK;
      bus.cmd_dr = 38'h2A_5555_AAAA;
      bus.cmd_valid = 1'b1;
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL scan_ready: got %b expected 1", bus.cmd_ready);
      end
      tick();
      // Changes after the accept edge must be ignored
      bus.cmd_valid = 1'b0;
      bus.cmd_ir = TRACEMEM;
      bus.cmd_dr = '0;
      seq = '0; last = '0; sdr_clks = 0; ir_bad = 0; n = 0;
      for (int k = 0; k < 2000; k++) begin
         cur = {uir, cdr, sdr, udr, rti};
         if (cur !== last) begin
            seq = {seq[24:0], cur};
            last = cur;
         end
         if (sdr === 1'b1) sdr_clks++;
         if (ir_in !== 2'd2) ir_bad++;
         if (bus.rsp_valid === 1'b1) break;
         tick();
         n++;
      end
      checks++;
      if (n != 168) begin
         failures++; $display("FAIL scan_latency: got %0d expected 168", n);
      end
      checks++;
      if (seq !== {5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b00000}) begin
         failures++; $display("FAIL scan_strobe_order: got %h expected %h", seq,
                              {5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b00000});
      end
      checks++;
      if (sdr_clks != 152) begin
         failures++; $display("FAIL scan_sdr_len: got %0d expected 152", sdr_clks);
      end
      checks++;
      if (ir_bad != 0) begin
         failures++; $display("FAIL scan_ir_in: got %0d bad cycles expected 0", ir_bad);
      end
      checks++;
      if (bus.rsp_dr !== 38'h15_0F0F_F0F0) begin
         failures++; $display("FAIL scan_rsp_dr: got %h expected 150f0ff0f0", bus.rsp_dr);
      end
      checks++;
      if (sr !== 38'h2A_5555_AAAA) begin
         failures++; $display("FAIL scan_slave_sr: got %h expected 2a5555aaaa", sr);
      end
   endtask

   task automatic test_rsp_hold();
      int n;
      bus.cmd_ir = OCIMEM;
      bus.cmd_dr = 38'h3F_0123_4567;
      bus.cmd_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if ({bus.rsp_valid, bus.cmd_ready, tck, uir} !== 4'b1000) begin
            failures++;
            $display("FAIL hold_cycle%0d: got %b expected 1000", i,
                     {bus.rsp_valid, bus.cmd_ready, tck, uir});
         end
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      checks++;
      if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
         failures++; $display("FAIL hold_release: got %b expected 01",
                              {bus.rsp_valid, bus.cmd_ready});
      end
      tick();
      bus.cmd_valid = 1'b0;
      checks++;
      if ({bus.cmd_ready, uir, ir_in} !== 4'b0100) begin
         failures++; $display("FAIL hold_accept: got %b expected 0100",
                              {bus.cmd_ready, uir, ir_in});
      end
      wait_rsp(n);
      checks++;
      if (n != 168 || bus.rsp_dr !== 38'h2A_5555_AAAA) begin
         failures++; $display("FAIL hold_rsp: got n=%0d dr=%h expected n=168 dr=2a5555aaaa",
                              n, bus.rsp_dr);
      end
      checks++;
      if (sr !== 38'h3F_0123_4567) begin
         failures++; $display("FAIL hold_slave_sr: got %h expected 3f01234567", sr);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      bus.rsp_ready = 1'b1;
      bus.cmd_ir = TRACECTRL;
      bus.cmd_dr = 38'h12_3456_789A;
      bus.cmd_valid = 1'b1;
      tick();
      checks++;
      if ({bus.cmd_ready, bus.rsp_valid} !== 2'b10) begin
         failures++; $display("FAIL b2b_ready_a: got %b expected 10",
                              {bus.cmd_ready, bus.rsp_valid});
      end
      tick();
      checks++;
      if ({uir, ir_in} !== 3'b111) begin
         failures++; $display("FAIL b2b_accept_a: got %b expected 111", {uir, ir_in});
      end
      bus.cmd_ir = TRACEMEM;
      bus.cmd_dr = 38'h01_FEDC_BA98;
      wait_rsp(n);
      checks++;
      if (n != 168 || bus.rsp_dr !== 38'h3F_0123_4567) begin
         failures++; $display("FAIL b2b_rsp_a: got n=%0d dr=%h expected n=168 dr=3f01234567",
                              n, bus.rsp_dr);
      end
      tick();
      checks++;
      if ({bus.cmd_ready, bus.rsp_valid} !== 2'b10) begin
         failures++; $display("FAIL b2b_ready_b: got %b expected 10",
                              {bus.cmd_ready, bus.rsp_valid});
      end
      tick();
      bus.cmd_valid = 1'b0;
      checks++;
      if ({uir, ir_in} !== 3'b101) begin
         failures++; $display("FAIL b2b_accept_b: got %b expected 101", {uir, ir_in});
      end
      wait_rsp(n);
      checks++;
      if (n != 168 || bus.rsp_dr !== 38'h12_3456_789A) begin
         failures++; $display("FAIL b2b_rsp_b: got n=%0d dr=%h expected n=168 dr=123456789a",
                              n, bus.rsp_dr);
      end
      tick();
      bus.rsp_ready = 1'b0;
      checks++;
      if (sr !== 38'h01_FEDC_BA98 || bus.rsp_valid !== 1'b0) begin
         failures++; $display("FAIL b2b_slave_sr: got %h rsp_valid=%b expected 01fedcba98 0",
                              sr, bus.rsp_valid);
      end
   endtask

   task automatic test_reset_mid_scan();
      int n, seen;
      load_sr(38'h0A_A5A5_5A5A);
      bus.cmd_ir = BREAK;
      bus.cmd_dr = 38'h05_1234_ABCD;
      bus.cmd_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      n = 0;
      while (sdr !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      repeat (17 * 4 + 1) tick();
      checks++;
      if (sdr !== 1'b1) begin
         failures++; $display("FAIL mid_in_sdr: got %b expected 1 (n=%0d)", sdr, n);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.cmd_ready, bus.rsp_valid, tck, tdi, uir, cdr, sdr, udr, rti, ir_in}
          !== 11'b1_0000_0000_00) begin
         failures++; $display("FAIL mid_reset_outputs: got %b expected 10000000000",
                              {bus.cmd_ready, bus.rsp_valid, tck, tdi, uir, cdr, sdr, udr, rti,
                               ir_in});
      end
      tick();
      tick();
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (bus.rsp_valid !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0 || bus.cmd_ready !== 1'b1) begin
         failures++; $display("FAIL mid_no_rsp: got %0d rsp cycles ready=%b expected 0 1",
                              seen, bus.cmd_ready);
      end
      load_sr(38'h2B_CDEF_0123);
      bus.cmd_ir = OCIMEM;
      bus.cmd_dr = 38'h1C_3C3C_C3C3;
      bus.cmd_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      wait_rsp(n);
      checks++;
      if (n != 168 || bus.rsp_dr !== 38'h2B_CDEF_0123) begin
         failures++; $display("FAIL mid_next_rsp: got n=%0d dr=%h expected n=168 dr=2bcdef0123",
                              n, bus.rsp_dr);
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      checks++;
      if (sr !== 38'h1C_3C3C_C3C3 || bus.cmd_ready !== 1'b1) begin
         failures++; $display("FAIL mid_next_sr: got %h ready=%b expected 1c3c3cc3c3 1",
                              sr, bus.cmd_ready);
      end
   endtask

   task automatic test_fast_tck();
      int n, rti_clks;
      logic [3:0] pat;
      load_sr2(38'h33_3333_CCCC);
      bus2.cmd_ir = TRACECTRL;
      bus2.cmd_dr = 38'h0F_F00F_1234;
      bus2.cmd_valid = 1'b1;
      bus2.rsp_ready = 1'b0;
      checks++;
      if (bus2.cmd_ready !== 1'b1) begin
         failures++; $display("FAIL fast_ready: got %b expected 1", bus2.cmd_ready);
      end
      tick();
      bus2.cmd_valid = 1'b0;
      n = 0; pat = '0; rti_clks = 0;
      for (int k = 0; k < 2000; k++) begin
         if (n < 4) pat = {pat[2:0], tck2};
         if (rti2 === 1'b1) rti_clks++;
         if (bus2.rsp_valid === 1'b1) break;
         tick();
         n++;
      end
      checks++;
      if (pat !== 4'b0101) begin
         failures++; $display("FAIL fast_tck_period: got %b expected 0101", pat);
      end
      checks++;
      if (n != 88) begin
         failures++; $display("FAIL fast_latency: got %0d expected 88", n);
      end
      checks++;
      if (rti_clks != 6) begin
         failures++; $display("FAIL fast_rti_len: got %0d expected 6", rti_clks);
      end
      checks++;
      if (bus2.rsp_dr !== 38'h33_3333_CCCC || sr2 !== 38'h0F_F00F_1234) begin
         failures++; $display("FAIL fast_data: got rsp=%h sr=%h expected 333333cccc 0ff00f1234",
                              bus2.rsp_dr, sr2);
      end
      bus2.rsp_ready = 1'b1;
      tick();
      bus2.rsp_ready = 1'b0;
      checks++;
      if ({bus2.cmd_ready, bus2.rsp_valid} !== 2'b10) begin
         failures++; $display("FAIL fast_release: got %b expected 10",
                              {bus2.cmd_ready, bus2.rsp_valid});
      end
   endtask

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_ir = '0; bus.cmd_dr = '0; bus.rsp_ready = 1'b0;
      bus2.cmd_valid = 1'b0; bus2.cmd_ir = '0; bus2.cmd_dr = '0; bus2.rsp_ready = 1'b0;
      test_reset();
      test_scan();
      test_rsp_hold();
      test_back_to_back();
      test_reset_mid_scan();
      test_fast_tck();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
